point_bbox_accum: RTL and testbench

- Downstream consumer of t_point streams, i.e. packed struct {x, y}, each logic unsigned [7:0], x in [15:8], y in [7:0].
- Accumulates a frame of points delivered over a valid/ready handshake and tracks the per-axis bounding box and point count.
- Presents one result record per frame, terminated by in_last, on a valid/ready output port.
- Sits between the point generators and the downstream geometry/overlay logic.

---
 rtl/point_bbox_accum.sv | 113 +++++++++++
 tb/tb_point_bbox_accum.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/point_bbox_accum.sv
// Frame-wise bounding-box and point-count accumulator for t_point streams.
// Points arrive on a valid/ready input. One result record (min, max, count,
// overflow flag) is presented per frame, which is terminated by in_last.
// Every output comes straight from a flop.
module point_bbox_accum #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_point,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_min,
  output logic [15:0]      out_max,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [15:0]      min_q, min_d;
  logic [15:0]      max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic accept;
  logic xfer;
  logic [7:0] px, py;

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;
  assign px     = in_point[15:8];
  assign py     = in_point[7:0];

  // Next-state and datapath update. Inputs are only looked at when a point is accepted.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          min_d   = in_point;
          max_d   = in_point;
          cnt_d   = CntOne;
          ovf_d   = 1'b0;
          state_d = in_last ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          // Axes are independent; strict compares keep ties unchanged.
          if (px < min_q[15:8]) min_d[15:8] = px;
          if (py < min_q[7:0])  min_d[7:0]  = py;
          if (px > max_q[15:8]) max_d[15:8] = px;
          if (py > max_q[7:0])  max_d[7:0]  = py;
          if (cnt_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
          if (in_last) state_d = StHold;
        end
      end
      StHold: begin
        if (xfer) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    in_ready_d  = (state_d != StHold);
    out_valid_d = (state_d == StHold);
  end

  // State and result registers; async reset returns all outputs to their idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      min_q       <= 16'hffff;
      max_q       <= 16'h0000;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_point_bbox_accum.sv
// Bench for point_bbox_accum: a default-width instance plus a CNT_W=2 instance
// share one stimulus stream; directed vector table followed by hand sequences.
module tb_point_bbox_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_point;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_min, out_max, out_cnt;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [15:0] s_out_min, s_out_max;
  logic [1:0]  s_out_cnt;

  int checks;
  int failures;

  point_bbox_accum #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_point(in_point), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  point_bbox_accum #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_point(in_point), .in_last(in_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_min(s_out_min), .out_max(s_out_max),
    .out_cnt(s_out_cnt), .out_ovf(s_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] pt;
    logic        il;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_min;
    logic [15:0] e_max;
    logic [15:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic ir, input logic ov,
                          input logic [15:0] mn, input logic [15:0] mx,
                          input logic [15:0] cnt, input logic ovf);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".out_min"},   {16'd0, out_min},   {16'd0, mn});
    chk({tag, ".out_max"},   {16'd0, out_max},   {16'd0, mx});
    chk({tag, ".out_cnt"},   {16'd0, out_cnt},   {16'd0, cnt});
    chk({tag, ".out_ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
  endtask

  task automatic chk_sat(input string tag, input logic [1:0] cnt, input logic ovf);
    chk({tag, ".s_out_cnt"}, {30'd0, s_out_cnt}, {30'd0, cnt});
    chk({tag, ".s_out_ovf"}, {31'd0, s_out_ovf}, {31'd0, ovf});
  endtask

  task automatic chk_reset(input string tag);
    chk_main(tag, 1'b1, 1'b0, 16'hffff, 16'h0000, 16'd0, 1'b0);
    chk_sat(tag, 2'd0, 1'b0);
    chk({tag, ".s_in_ready"}, {31'd0, s_in_ready}, 32'd1);
    chk({tag, ".s_out_valid"}, {31'd0, s_out_valid}, 32'd0);
  endtask

  // Drive one cycle of inputs, clock, then sample 1ns after the edge.
  task automatic step(input logic iv, input logic [15:0] pt, input logic il, input logic ordy);
    in_valid  = iv;
    in_point  = pt;
    in_last   = il;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    //         iv    pt       il    ordy  e_ir  e_ov  e_min     e_max     e_cnt  e_ovf
    vecs[0]  = '{1'b1, 16'h0AC8, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0AC8, 16'h0AC8, 16'd1, 1'b0};
    vecs[1]  = '{1'b1, 16'h3214, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0A14, 16'h32C8, 16'd2, 1'b0};
    vecs[2]  = '{1'b1, 16'h1E5A, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0A14, 16'h32C8, 16'd3, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0A14, 16'h32C8, 16'd3, 1'b0};
    vecs[4]  = '{1'b1, 16'hFF00, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFF00, 16'hFF00, 16'd1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFF00, 16'hFF00, 16'd1, 1'b0};
    vecs[6]  = '{1'b1, 16'h00FF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h00FF, 16'd1, 1'b0};
    vecs[7]  = '{1'b1, 16'hFF00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'd2, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'd2, 1'b0};
    vecs[9]  = '{1'b1, 16'h0505, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0505, 16'h0505, 16'd1, 1'b0};
    vecs[10] = '{1'b1, 16'h0505, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0505, 16'h0505, 16'd2, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0505, 16'h0505, 16'd2, 1'b0};
    vecs[12] = '{1'b1, 16'h141E, 1'b0, 1'b1, 1'b1, 1'b0, 16'h141E, 16'h141E, 16'd1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h141E, 16'h141E, 16'd1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h141E, 16'h141E, 16'd1, 1'b0};
    vecs[15] = '{1'b1, 16'h190A, 1'b1, 1'b1, 1'b0, 1'b1, 16'h140A, 16'h191E, 16'd2, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h140A, 16'h191E, 16'd2, 1'b0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_point  = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset, sampled before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: basic frame, single-point/extremes, ties, pause and stray in_last.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].iv, vecs[i].pt, vecs[i].il, vecs[i].ordy);
      chk_main($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_min,
               vecs[i].e_max, vecs[i].e_cnt, vecs[i].e_ovf);
    end

    // Backpressure: result held while out_ready low, offered point waits.
    step(1'b1, 16'h0102, 1'b0, 1'b0);
    chk_main("bp_p0", 1'b1, 1'b0, 16'h0102, 16'h0102, 16'd1, 1'b0);
    step(1'b1, 16'h0304, 1'b1, 1'b0);
    chk_main("bp_last", 1'b0, 1'b1, 16'h0102, 16'h0304, 16'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h0909, 1'b0, 1'b0);
      chk_main($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 16'h0102, 16'h0304, 16'd2, 1'b0);
    end
    step(1'b1, 16'h0909, 1'b0, 1'b1);
    chk_main("bp_xfer", 1'b1, 1'b0, 16'h0102, 16'h0304, 16'd2, 1'b0);
    step(1'b1, 16'h0909, 1'b0, 1'b0);
    chk_main("bp_next_first", 1'b1, 1'b0, 16'h0909, 16'h0909, 16'd1, 1'b0);
    step(1'b1, 16'h0909, 1'b1, 1'b0);
    chk_main("bp_next_last", 1'b0, 1'b1, 16'h0909, 16'h0909, 16'd2, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_main("bp_next_xfer", 1'b1, 1'b0, 16'h0909, 16'h0909, 16'd2, 1'b0);

    // Saturation: 5-point frame on the 2-bit counter instance.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, {k[7:0], k[7:0]}, (k == 5), 1'b0);
      if (k == 4) chk_sat("sat_p4", 2'd3, 1'b1);
    end
    chk_main("sat_wide", 1'b0, 1'b1, 16'h0101, 16'h0505, 16'd5, 1'b0);
    chk_sat("sat_narrow", 2'd3, 1'b1);
    chk({"sat_narrow", ".s_out_min"}, {16'd0, s_out_min}, 32'h0101);
    chk({"sat_narrow", ".s_out_max"}, {16'd0, s_out_max}, 32'h0505);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h0208, 1'b0, 1'b0);
    step(1'b1, 16'h0603, 1'b1, 1'b0);
    chk_main("sat_after", 1'b0, 1'b1, 16'h0203, 16'h0608, 16'd2, 1'b0);
    chk_sat("sat_after", 2'd2, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Reset mid-frame discards the partial frame.
    step(1'b1, 16'h0130, 1'b0, 1'b0);
    step(1'b1, 16'h4002, 1'b0, 1'b0);
    chk_main("rst_pre", 1'b1, 1'b0, 16'h0102, 16'h4030, 16'd2, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0707, 1'b1, 1'b0);
    chk_main("rst_after", 1'b0, 1'b1, 16'h0707, 16'h0707, 16'd1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_main("rst_after_xfer", 1'b1, 1'b0, 16'h0707, 16'h0707, 16'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
